// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode constants and pointer sizing.
package fifo_pkg;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

  // Address bits plus one wrap bit, so full and empty stay distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bundle for fifo_sync_param; the FIFO is the slave side.
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = ptr_width(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic             flush;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, wr_data, rd_en, flush,
    input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, flush,
    output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage: registered write, asynchronous read. Contents are not reset.
module fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// occupancy count, almost thresholds, synchronous flush and sticky error flags.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AFULL_TH  = DEPTH - 2,
  parameter int unsigned AEMPTY_TH = 2,
  parameter int unsigned FWFT      = FIFO_STD
) (
  input logic         clk,
  input logic         rst_n,
  fifo_sync_param_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two and at least 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH || AEMPTY_TH > DEPTH - 1) begin : g_bad_th
    $error("fifo_sync_param: AFULL_TH or AEMPTY_TH out of range");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_w;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             empty_w, full_w, rd_acc, wr_acc;
  logic [WIDTH-1:0] mem_rdata;

  assign count_w = wr_ptr_q - rd_ptr_q;
  assign empty_w = (count_w == '0);
  assign full_w  = (count_w == PW'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired write.
  assign rd_acc = bus.rd_en & ~empty_w & ~bus.flush;
  assign wr_acc = bus.wr_en & (~full_w | rd_acc) & ~bus.flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      if (bus.wr_en && !wr_acc) ovf_d = 1'b1;
      if (bus.rd_en && empty_w) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign bus.rd_data = mem_rdata;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
      rd_data_d = rd_data_q;
      if (rd_acc) rd_data_d = mem_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
    end

    assign bus.rd_data = rd_data_q;
  end

  assign bus.count        = count_w;
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_full  = (count_w >= PW'(AFULL_TH));
  assign bus.almost_empty = (count_w <= PW'(AEMPTY_TH));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule
